// File: rtl/dcache_wb_controller_pkg.sv
// Shared types and default geometry for the write-back data cache controller.
package core_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_WB_REQ,
        ST_RF_REQ,
        ST_RF_WAIT,
        ST_RESP
    } dcache_state_e;

    localparam int DCACHE_SETS        = 64;
    localparam int DCACHE_WAYS        = 2;
    localparam int DCACHE_BLOCK_WORDS = 8;

endpackage

// File: rtl/dcache_wb_controller_way_store.sv
// One cache way: tag/valid/dirty/data arrays with asynchronous read,
// a byte-masked single-word write and a whole-block refill write.
module dcache_way_store #(
    parameter int TAG_W       = 21,
    parameter int IDX_W       = 6,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                            clk,
    input  logic [IDX_W-1:0]                idx,
    input  logic                            clear_en,
    input  logic                            fill_en,
    input  logic [TAG_W-1:0]                fill_tag,
    input  logic [WORD_W*BLOCK_WORDS-1:0]   fill_block,
    input  logic                            word_en,
    input  logic [$clog2(BLOCK_WORDS)-1:0]  word_off,
    input  logic [WORD_W-1:0]               word_data,
    input  logic [WORD_W/8-1:0]             word_strb,
    output logic [TAG_W-1:0]                tag,
    output logic                            valid,
    output logic                            dirty,
    output logic [WORD_W*BLOCK_WORDS-1:0]   block
);

    localparam int SETS    = 1 << IDX_W;
    localparam int BLOCK_W = WORD_W * BLOCK_WORDS;
    localparam int STRB_W  = WORD_W / 8;

    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [BLOCK_W-1:0] data_mem [SETS];
    logic [SETS-1:0]    valid_mem;
    logic [SETS-1:0]    dirty_mem;

    assign tag   = tag_mem[idx];
    assign valid = valid_mem[idx];
    assign dirty = dirty_mem[idx];
    assign block = data_mem[idx];

    // Data arrays are never reset; the controller's sweep clears valid/dirty.
    always_ff @(posedge clk) begin
        if (clear_en) begin
            valid_mem[idx] <= 1'b0;
            dirty_mem[idx] <= 1'b0;
        end else if (fill_en) begin
            tag_mem[idx]   <= fill_tag;
            data_mem[idx]  <= fill_block;
            valid_mem[idx] <= 1'b1;
            dirty_mem[idx] <= 1'b0;
        end else if (word_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (word_strb[b])
                    data_mem[idx][int'(word_off)*WORD_W + b*8 +: 8] <= word_data[b*8 +: 8];
            end
            if (|word_strb)
                dirty_mem[idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_wb_controller.sv
// Blocking write-back, write-allocate data cache controller (1 or 2 ways, LRU)
// with a power-up invalidation sweep and a block-wide memory interface.
module dcache_wb_controller
    import core_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = DCACHE_BLOCK_WORDS,
    parameter int NUM_SETS    = DCACHE_SETS,
    parameter int NUM_WAYS    = DCACHE_WAYS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [WORD_W-1:0]               req_wdata,
    input  logic [WORD_W/8-1:0]             req_wstrb,
    output logic                            resp_valid,
    output logic [WORD_W-1:0]               resp_rdata,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_req_we,
    output logic [ADDR_W-1:0]               mem_req_addr,
    output logic [WORD_W*BLOCK_WORDS-1:0]   mem_wdata,
    input  logic                            mem_resp_valid,
    input  logic [WORD_W*BLOCK_WORDS-1:0]   mem_rdata,
    output logic                            init_done,
    output dcache_state_e                   state_dbg
);

    localparam int WOFF_W  = $clog2(BLOCK_WORDS);
    localparam int OFF_W   = WOFF_W + 2;
    localparam int IDX_W   = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
    localparam int BLOCK_W = WORD_W * BLOCK_WORDS;
    localparam int STRB_W  = WORD_W / 8;

    dcache_state_e       state;
    logic [IDX_W-1:0]    sweep_idx;
    logic [NUM_SETS-1:0] lru;
    logic                q_we;
    logic [ADDR_W-3:0]   q_waddr;
    logic [WORD_W-1:0]   q_wdata;
    logic [STRB_W-1:0]   q_wstrb;
    logic                victim_q;

    wire unused_addr_bits = ^req_addr[1:0];

    logic [TAG_W-1:0]  q_tag;
    logic [IDX_W-1:0]  q_idx;
    logic [WOFF_W-1:0] q_woff;
    logic [IDX_W-1:0]  store_idx;

    assign q_tag     = q_waddr[ADDR_W-3 -: TAG_W];
    assign q_idx     = q_waddr[OFF_W-2 +: IDX_W];
    assign q_woff    = q_waddr[WOFF_W-1:0];
    assign store_idx = (state == ST_INIT) ? sweep_idx : q_idx;

    logic [TAG_W-1:0]    w_tag   [NUM_WAYS];
    logic [BLOCK_W-1:0]  w_block [NUM_WAYS];
    logic [NUM_WAYS-1:0] w_valid, w_dirty, w_hit, fill_en, word_en;
    logic                clear_en;

    assign clear_en = !rst && (state == ST_INIT);

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        dcache_way_store #(
            .TAG_W(TAG_W), .IDX_W(IDX_W), .WORD_W(WORD_W), .BLOCK_WORDS(BLOCK_WORDS)
        ) u_way (
            .clk        (clk),
            .idx        (store_idx),
            .clear_en   (clear_en),
            .fill_en    (fill_en[w]),
            .fill_tag   (q_tag),
            .fill_block (mem_rdata),
            .word_en    (word_en[w]),
            .word_off   (q_woff),
            .word_data  (q_wdata),
            .word_strb  (q_wstrb),
            .tag        (w_tag[w]),
            .valid      (w_valid[w]),
            .dirty      (w_dirty[w]),
            .block      (w_block[w])
        );
        assign w_hit[w]   = w_valid[w] && (w_tag[w] == q_tag);
        assign fill_en[w] = !rst && (state == ST_RF_WAIT) && mem_resp_valid && (victim_q == 1'(w));
        assign word_en[w] = !rst && q_we &&
                            (((state == ST_LOOKUP) && w_hit[w]) ||
                             ((state == ST_RESP) && (victim_q == 1'(w))));
    end

    logic hit, hit_way, victim;
    assign hit = |w_hit;

    // Descending scan so the lowest-index invalid way wins over the LRU pick.
    always_comb begin
        hit_way = 1'b0;
        victim  = (NUM_WAYS == 2) ? lru[q_idx] : 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (w_hit[w])   hit_way = 1'(w);
            if (!w_valid[w]) victim = 1'(w);
        end
    end

    logic [BLOCK_W-1:0] sel_block;
    logic [WORD_W-1:0]  sel_word;
    assign sel_block = w_block[(state == ST_LOOKUP) ? hit_way : victim_q];
    assign sel_word  = sel_block[int'(q_woff)*WORD_W +: WORD_W];

    // All outputs decode from registered state, so memory request fields hold
    // steady for as long as the FSM waits in a request state.
    assign req_ready     = (state == ST_IDLE);
    assign resp_valid    = ((state == ST_LOOKUP) && hit) || (state == ST_RESP);
    assign resp_rdata    = (resp_valid && !q_we) ? sel_word : '0;
    assign mem_req_valid = (state == ST_WB_REQ) || (state == ST_RF_REQ);
    assign mem_req_we    = (state == ST_WB_REQ);
    assign mem_req_addr  = (state == ST_WB_REQ) ? {w_tag[victim_q], q_idx, {OFF_W{1'b0}}} :
                           (state == ST_RF_REQ) ? {q_tag, q_idx, {OFF_W{1'b0}}} : '0;
    assign mem_wdata     = (state == ST_WB_REQ) ? w_block[victim_q] : '0;
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
            init_done <= 1'b0;
            victim_q  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    lru[sweep_idx] <= 1'b0;
                    if (sweep_idx == IDX_W'(NUM_SETS - 1)) begin
                        init_done <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                ST_IDLE: if (req_valid) begin
                    q_we    <= req_we;
                    q_waddr <= req_addr[ADDR_W-1:2];
                    q_wdata <= req_wdata;
                    q_wstrb <= req_wstrb;
                    state   <= ST_LOOKUP;
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        lru[q_idx] <= ~hit_way;
                        state      <= ST_IDLE;
                    end else begin
                        victim_q <= victim;
                        state    <= (w_valid[victim] && w_dirty[victim]) ? ST_WB_REQ : ST_RF_REQ;
                    end
                end
                ST_WB_REQ:  if (mem_req_ready) state <= ST_RF_REQ;
                ST_RF_REQ:  if (mem_req_ready) state <= ST_RF_WAIT;
                ST_RF_WAIT: if (mem_resp_valid) begin
                    lru[q_idx] <= ~victim_q;
                    state      <= ST_RESP;
                end
                ST_RESP:    state <= ST_IDLE;
                default:    state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wb_controller.sv
// Bench for dcache_wb_controller: flat memory image plus a recency-ordered
// resident-block list predict hits, evictions, writebacks and load data.
module tb_dcache_wb_controller;
    import core_pkg::*;

    localparam int BW = 256;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [31:0]     req_addr = '0;
    logic [31:0]     req_wdata = '0;
    logic [3:0]      req_wstrb = '0;
    logic            resp_valid;
    logic [31:0]     resp_rdata;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b0;
    logic            mem_req_we;
    logic [31:0]     mem_req_addr;
    logic [BW-1:0]   mem_wdata;
    logic            mem_resp_valid = 1'b0;
    logic [BW-1:0]   mem_rdata = {8{32'hBAD0_BAD0}};
    logic            init_done;
    dcache_state_e   state_dbg;

    dcache_wb_controller dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .init_done(init_done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] dram    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          dirty_m [logic [31:0]];
    logic [31:0] res_q   [$];
    logic [31:0] exp_q   [$];

    function automatic logic [31:0] def_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return def_word(a);
    endfunction

    function automatic logic [31:0] rd_dram(input logic [31:0] a);
        if (dram.exists(a)) return dram[a];
        return def_word(a);
    endfunction

    // Lines lost on reset are exactly the dirty ones, so memory reverts to DRAM.
    task automatic model_reset();
        res_q.delete();
        dirty_m.delete();
        ref_mem = dram;
    endtask

    task automatic preload_block(input logic [31:0] base);
        for (int k = 0; k < 8; k++) begin
            dram[base + 32'(k*4)]    = 32'hA0 + 32'(k);
            ref_mem[base + 32'(k*4)] = 32'hA0 + 32'(k);
        end
    endtask

    task automatic count_sweep(output int cnt, output bit busy);
        cnt = 0; busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            cnt++;
            if (init_done) break;
            if (req_ready || resp_valid || mem_req_valid) busy = 1;
        end
    endtask

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] ws, input int stall,
                             output logic [31:0] got, output logic saw_wb,
                             output logic [31:0] wb_addr, output logic saw_rf);
        logic [31:0] blk, vblk, w, hold_addr, exp_d;
        logic [BW-1:0] exp_blk, hold_data, rf_blk;
        logic hit, has_victim, v_dirty, found, ok;
        int set_cnt, vpos, hpos;
        got = '0; saw_wb = 0; wb_addr = '0; saw_rf = 0;
        blk = {addr[31:5], 5'd0};
        hit = 0; set_cnt = 0; vpos = -1; hpos = -1;
        foreach (res_q[i]) begin
            if (res_q[i] == blk) begin hit = 1; hpos = i; end
            if (res_q[i][10:5] == blk[10:5]) begin set_cnt++; vpos = i; end
        end
        has_victim = !hit && (set_cnt == 2);
        vblk    = has_victim ? res_q[vpos] : 32'h0;
        v_dirty = has_victim && dirty_m.exists(vblk) && dirty_m[vblk];
        exp_blk = '0;
        for (int k = 0; k < 8; k++) exp_blk[k*32 +: 32] = rd_ref(vblk + 32'(k*4));
        exp_q.push_back(we ? 32'h0 : rd_ref({addr[31:2], 2'b00}));

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            if (req_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL accept: req_ready never 1 for addr %h", addr);
            req_valid = 1'b0; exp_d = exp_q.pop_front(); return;
        end
        @(negedge clk);
        req_valid = 1'b0;

        if (hit) begin
            checks++;
            if (resp_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL hit_lookup: addr %h resp_valid=%b mem_req_valid=%b, expected 1/0",
                         addr, resp_valid, mem_req_valid);
            end
            got = resp_rdata;
        end else begin
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++; $display("FAIL miss_lookup: addr %h resp_valid=%b expected 0", addr, resp_valid);
            end
            if (v_dirty) begin
                found = 0;
                for (int i = 0; i < 20; i++) begin
                    if (mem_req_valid) begin found = 1; break; end
                    @(negedge clk);
                end
                checks++;
                if (!found || mem_req_we !== 1'b1 || mem_req_addr !== vblk || mem_wdata !== exp_blk) begin
                    errors++;
                    $display("FAIL wb_req: valid=%b we=%b addr=%h data=%h, expected 1/1/%h data=%h",
                             found, mem_req_we, mem_req_addr, mem_wdata, vblk, exp_blk);
                end
                if (!found) begin exp_d = exp_q.pop_front(); return; end
                saw_wb = 1; wb_addr = mem_req_addr;
                hold_addr = mem_req_addr; hold_data = mem_wdata;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    checks++;
                    if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== hold_addr ||
                        mem_wdata !== hold_data || req_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL wb_hold: cycle %0d valid=%b we=%b addr=%h req_ready=%b, expected 1/1/%h/0",
                                 s, mem_req_valid, mem_req_we, mem_req_addr, req_ready, hold_addr);
                    end
                end
                mem_req_ready = 1'b1;
                @(negedge clk);
                mem_req_ready = 1'b0;
                for (int k = 0; k < 8; k++) dram[hold_addr + 32'(k*4)] = hold_data[k*32 +: 32];
            end
            found = 0;
            for (int i = 0; i < 20; i++) begin
                if (mem_req_valid) begin found = 1; break; end
                @(negedge clk);
            end
            checks++;
            if (!found || mem_req_we !== 1'b0 || mem_req_addr !== blk) begin
                errors++;
                $display("FAIL rf_req: valid=%b we=%b addr=%h, expected 1/0/%h", found, mem_req_we, mem_req_addr, blk);
            end
            if (!found) begin exp_d = exp_q.pop_front(); return; end
            saw_rf = 1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            ok = 1;
            repeat ($urandom_range(0, 3)) begin
                if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0) ok = 0;
                @(negedge clk);
            end
            checks++;
            if (!ok || mem_req_valid !== 1'b0) begin
                errors++; $display("FAIL rf_wait: mem_req_valid=%b resp_valid=%b, expected 0/0", mem_req_valid, resp_valid);
            end
            for (int k = 0; k < 8; k++) rf_blk[k*32 +: 32] = rd_dram(blk + 32'(k*4));
            mem_rdata = rf_blk; mem_resp_valid = 1'b1;
            @(negedge clk);
            mem_resp_valid = 1'b0; mem_rdata = {8{32'hBAD0_BAD0}};
            checks++;
            if (resp_valid !== 1'b1) begin
                errors++; $display("FAIL refill_resp: resp_valid=%b expected 1", resp_valid);
            end
            got = resp_rdata;
        end

        exp_d = exp_q.pop_front();
        checks++;
        if (got !== exp_d) begin
            errors++; $display("FAIL resp_data: addr %h we=%b got %h expected %h", addr, we, got, exp_d);
        end

        if (we) begin
            w = rd_ref({addr[31:2], 2'b00});
            for (int b = 0; b < 4; b++) if (ws[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[{addr[31:2], 2'b00}] = w;
        end
        if (has_victim) begin res_q.delete(vpos); dirty_m.delete(vblk); end
        if (hit) res_q.delete(hpos);
        else dirty_m[blk] = 0;
        res_q.push_front(blk);
        if (we && ws != 4'h0) dirty_m[blk] = 1;
    endtask

    task automatic test_reset();
        int cnt; bit busy;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || mem_req_valid !== 1'b0 ||
            mem_req_we !== 1'b0 || mem_req_addr !== 32'h0 || init_done !== 1'b0 || state_dbg !== ST_INIT) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b resp=%b rdata=%h mvalid=%b mwe=%b maddr=%h done=%b state=%0d, expected all 0 / INIT",
                     req_ready, resp_valid, resp_rdata, mem_req_valid, mem_req_we, mem_req_addr, init_done, state_dbg);
        end
        rst = 1'b0;
        model_reset();
        count_sweep(cnt, busy);
        checks++;
        if (cnt != 64 || busy) begin
            errors++; $display("FAIL init_sweep: done after %0d cycles busy=%b, expected 64 and 0", cnt, busy);
        end
    endtask

    task automatic test_refill_hit();
        logic [31:0] got, wba; logic wb, rf;
        preload_block(32'h1000);
        do_access(1'b0, 32'h1000, 32'h0, 4'h0, 0, got, wb, wba, rf);
        checks++;
        if (got !== 32'hA0 || rf !== 1'b1 || wb !== 1'b0) begin
            errors++; $display("FAIL first_load: data %h rf=%b wb=%b, expected 000000a0 1 0", got, rf, wb);
        end
        do_access(1'b0, 32'h1004, 32'h0, 4'h0, 0, got, wb, wba, rf);
        checks++;
        if (got !== 32'hA1 || rf !== 1'b0) begin
            errors++; $display("FAIL hit_load: data %h rf=%b, expected 000000a1 0", got, rf);
        end
    endtask

    task automatic test_store_merge();
        logic [31:0] got, wba; logic wb, rf;
        do_access(1'b1, 32'h1008, 32'hDEAD_BEEF, 4'h3, 0, got, wb, wba, rf);
        do_access(1'b0, 32'h1008, 32'h0, 4'h0, 0, got, wb, wba, rf);
        checks++;
        if (got !== 32'h0000_BEEF) begin
            errors++; $display("FAIL store_merge: data %h expected 0000beef", got);
        end
        do_access(1'b1, 32'h100C, 32'h1111_2222, 4'h0, 0, got, wb, wba, rf);
        do_access(1'b0, 32'h100C, 32'h0, 4'h0, 0, got, wb, wba, rf);
        checks++;
        if (got !== 32'hA3) begin
            errors++; $display("FAIL zero_strb: data %h expected 000000a3", got);
        end
    endtask

    task automatic test_evict_writeback();
        logic [31:0] got, wba; logic wb, rf;
        do_access(1'b1, 32'h1000, 32'h1234_5678, 4'hF, 0, got, wb, wba, rf);
        do_access(1'b0, 32'h2000, 32'h0, 4'h0, 0, got, wb, wba, rf);
        do_access(1'b0, 32'h1000, 32'h0, 4'h0, 0, got, wb, wba, rf);
        checks++;
        if (rf !== 1'b0 || got !== 32'h1234_5678) begin
            errors++; $display("FAIL reuse_hit: rf=%b data %h, expected 0 12345678", rf, got);
        end
        do_access(1'b0, 32'h3000, 32'h0, 4'h0, 0, got, wb, wba, rf);
        checks++;
        if (wb !== 1'b0 || rf !== 1'b1) begin
            errors++; $display("FAIL clean_evict: wb=%b rf=%b, expected 0 1", wb, rf);
        end
        do_access(1'b0, 32'h4000, 32'h0, 4'h0, 10, got, wb, wba, rf);
        checks++;
        if (wb !== 1'b1 || wba !== 32'h1000 || rf !== 1'b1) begin
            errors++; $display("FAIL dirty_evict: wb=%b addr %h rf=%b, expected 1 00001000 1", wb, wba, rf);
        end
        do_access(1'b0, 32'h1000, 32'h0, 4'h0, 0, got, wb, wba, rf);
        checks++;
        if (got !== 32'h1234_5678 || rf !== 1'b1) begin
            errors++; $display("FAIL writeback_data: data %h rf=%b, expected 12345678 1", got, rf);
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] got, wba; logic wb, rf, found, ok;
        int cnt; bit busy;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2000; req_wstrb = 4'h0;
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            if (req_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid && !mem_req_we) begin found = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++;
        if (!ok || !found || state_dbg !== ST_RF_WAIT || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reach_rf_wait: accepted=%b rf_seen=%b state=%0d, expected 1 1 RF_WAIT", ok, found, state_dbg);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rdata = {8{32'hFFFF_0000}}; mem_resp_valid = 1'b1;
        checks++;
        if (mem_req_valid !== 1'b0 || init_done !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: mem_req_valid=%b init_done=%b resp_valid=%b, expected 0/0/0",
                               mem_req_valid, init_done, resp_valid);
        end
        model_reset();
        count_sweep(cnt, busy);
        mem_rdata = {8{32'hBAD0_BAD0}};
        checks++;
        if (cnt != 64 || busy) begin
            errors++; $display("FAIL resweep: done after %0d cycles busy=%b, expected 64 and 0", cnt, busy);
        end
        do_access(1'b0, 32'h1000, 32'h0, 4'h0, 0, got, wb, wba, rf);
        checks++;
        if (rf !== 1'b1 || got !== 32'h1234_5678) begin
            errors++; $display("FAIL post_reset_miss: rf=%b data %h, expected 1 12345678", rf, got);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, wba, a, d; logic wb, rf, we; logic [3:0] ws;
        for (int n = 0; n < 150; n++) begin
            a = (32'($urandom_range(1, 4)) << 11) | (32'($urandom_range(0, 1)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            ws = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_access(we, a, d, ws, $urandom_range(0, 3), got, wb, wba, rf);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_refill_hit();
        test_store_merge();
        test_evict_writeback();
        test_reset_mid_refill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
